alu_seq: RTL and testbench

Single-issue sequencer for the 8-bit graphics ALU, sitting on the issuing side of the ALU's a/b/n → r/cc interface. It accepts one packed instruction at a time over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU operand and opcode ports, waits a parameterised latency, then captures the result and condition codes. Finally it writes back the result and presents a response on a second valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/gfx_regfile.sv | 32 +++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the graphics ALU sequencer.
// Instruction layout, flag indices and FSM states live here.
package alu_seq_pkg;

    localparam int DW      = 8;
    localparam int NREG    = 4;
    localparam int RAW     = 2;
    localparam int INSTR_W = 19;

    localparam int IN_N_HI  = 18;
    localparam int IN_N_LO  = 16;
    localparam int IN_RD_HI = 15;
    localparam int IN_RD_LO = 14;
    localparam int IN_RA_HI = 13;
    localparam int IN_RA_LO = 12;
    localparam int IN_RB_HI = 11;
    localparam int IN_RB_LO = 10;
    localparam int IN_UIMM  = 9;
    localparam int IN_COND  = 8;
    localparam int IN_IM_HI = 7;
    localparam int IN_IM_LO = 0;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [2:0]    n;
        logic [RAW-1:0] rd;
        logic [RAW-1:0] ra;
        logic [RAW-1:0] rb;
        logic          use_imm;
        logic          cond;
        logic [DW-1:0] imm;
    } instr_t;

endpackage

// File: rtl/gfx_regfile.sv
// 4x8 register file: one write port, two combinational read ports.
// All registers clear on asynchronous active-low reset.
module gfx_regfile
    import alu_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we_i,
    input  logic [RAW-1:0] waddr_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic [RAW-1:0] raddr_a_i,
    output logic [DW-1:0]  rdata_a_o,
    input  logic [RAW-1:0] raddr_b_i,
    output logic [DW-1:0]  rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_seq.sv
// Single-issue sequencer driving the graphics ALU a/b/n -> r/cc port.
// Accepts one instruction, waits ALU_LAT cycles, writes back, responds.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [2:0]         alu_n,
    input  logic [DW-1:0]      alu_r,
    input  logic [3:0]         alu_cc,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DW-1:0]      res_data,
    output logic [3:0]         res_cc,
    output logic [RAW-1:0]     res_rd,
    output logic               res_skip
);

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           up_q;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [2:0]     n_q, n_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic           cond_q, cond_d;
    logic [3:0]     cc_q, cc_d;
    logic [DW-1:0]  rdat_q, rdat_d;
    logic [3:0]     rcc_q, rcc_d;
    logic           skip_q, skip_d;

    instr_t         in_s;
    logic [DW-1:0]  rf_a;
    logic [DW-1:0]  rf_b;
    logic           accept;
    logic           last;
    logic           squash;
    logic           we;

    assign in_s   = instr_t'(instr);
    assign accept = instr_valid && instr_ready;
    assign last   = (state_q == S_WAIT) && (cnt_q == 3'd0);
    assign squash = cond_q && cc_q[CC_Z];
    assign we     = last && !squash;

    gfx_regfile u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (we),
        .waddr_i   (rd_q),
        .wdata_i   (alu_r),
        .raddr_a_i (in_s.ra),
        .rdata_a_o (rf_a),
        .raddr_b_i (in_s.rb),
        .rdata_b_o (rf_b)
    );

    // up_q keeps ready low while reset is held and for no longer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            rd_q    <= '0;
            cond_q  <= 1'b0;
            cc_q    <= '0;
            rdat_q  <= '0;
            rcc_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            rd_q    <= rd_d;
            cond_q  <= cond_d;
            cc_q    <= cc_d;
            rdat_q  <= rdat_d;
            rcc_q   <= rcc_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        rd_d    = rd_q;
        cond_d  = cond_q;
        cc_d    = cc_q;
        rdat_d  = rdat_q;
        rcc_d   = rcc_q;
        skip_d  = skip_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = rf_a;
                    b_d     = in_s.use_imm ? in_s.imm : rf_b;
                    n_d     = in_s.n;
                    rd_d    = in_s.rd;
                    cond_d  = in_s.cond;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (squash) begin
                        rdat_d = '0;
                        rcc_d  = cc_q;
                        skip_d = 1'b1;
                    end else begin
                        cc_d   = alu_cc;
                        rdat_d = alu_r;
                        rcc_d  = alu_cc;
                        skip_d = 1'b0;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_ready = up_q && (state_q == S_IDLE);
    assign res_valid   = (state_q == S_RESP);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_n       = n_q;
    assign res_data    = rdat_q;
    assign res_cc      = rcc_q;
    assign res_rd      = rd_q;
    assign res_skip    = skip_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq: two builds (ALU_LAT=1 and 4) against
// a register/flag reference model and a latency-aware ALU model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        iv    [2];
    logic        rr    [2];
    logic [18:0] ins_w [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic [7:0]  ao    [2];
    logic [7:0]  bo    [2];
    logic [2:0]  no    [2];
    logic [7:0]  rd_o  [2];
    logic [3:0]  rc_o  [2];
    logic [1:0]  rrd_o [2];
    logic        rs_o  [2];

    logic [7:0]  m_r  [2][4];
    logic [3:0]  m_cc [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Returns {N,Z,C,V, r}; C is carry for ADD and borrow for SUB.
    function automatic logic [11:0] alu(input logic [2:0] n,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
        logic [8:0] t;
        logic       c;
        logic       v;
        t = '0;
        c = 1'b0;
        v = 1'b0;
        case (n)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b};
                c = t[8];
                v = (a[7] == b[7]) && (t[7] != a[7]);
            end
            3'd1: begin
                t = {1'b0, a} - {1'b0, b};
                c = t[8];
                v = (a[7] != b[7]) && (t[7] != a[7]);
            end
            3'd2: t[7:0] = a & b;
            3'd3: t[7:0] = a | b;
            3'd4: t[7:0] = a ^ b;
            3'd5: t[7:0] = a;
            3'd6: t[7:0] = b;
            default: t[7:0] = ~a;
        endcase
        return {t[7], t[7:0] == 8'd0, c, v, t[7:0]};
    endfunction

    function automatic logic [18:0] mk(input int n, input int rd,
                                       input int ra, input int rb,
                                       input int ui, input int cd,
                                       input int im);
        return {3'(n), 2'(rd), 2'(ra), 2'(rb), 1'(ui), 1'(cd), 8'(im)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [7:0]  alu_r;
        logic [3:0]  alu_cc;
        logic [18:0] last = '0;
        int          age  = 0;
        logic [11:0] f;

        // r/cc are only trustworthy LAT cycles after operands settle.
        always @(posedge clk) begin
            if ({ao[g], bo[g], no[g]} != last) begin
                last <= {ao[g], bo[g], no[g]};
                age  <= 0;
            end else if (age < 15) begin
                age <= age + 1;
            end
        end

        always_comb begin
            f = alu(no[g], ao[g], bo[g]);
            if (age >= LAT - 1) {alu_cc, alu_r} = f;
            else                {alu_cc, alu_r} = ~f;
        end

        alu_seq #(.ALU_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .instr_valid (iv[g]),
            .instr_ready (rdy[g]),
            .instr       (ins_w[g]),
            .alu_a       (ao[g]),
            .alu_b       (bo[g]),
            .alu_n       (no[g]),
            .alu_r       (alu_r),
            .alu_cc      (alu_cc),
            .res_valid   (rv[g]),
            .res_ready   (rr[g]),
            .res_data    (rd_o[g]),
            .res_cc      (rc_o[g]),
            .res_rd      (rrd_o[g]),
            .res_skip    (rs_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic check_zero(input int k);
        check("z_valid", 32'(rv[k]), 0);
        check("z_a", 32'(ao[k]), 0);
        check("z_b", 32'(bo[k]), 0);
        check("z_n", 32'(no[k]), 0);
        check("z_data", 32'(rd_o[k]), 0);
        check("z_cc", 32'(rc_o[k]), 0);
        check("z_rd", 32'(rrd_o[k]), 0);
        check("z_skip", 32'(rs_o[k]), 0);
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 4; i++) m_r[k][i] = '0;
        m_cc[k] = '0;
    endtask

    task automatic do_instr(input int k, input logic [18:0] ins,
                            input int hold);
        logic [2:0]  n;
        logic [1:0]  rd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] f;
        logic [7:0]  e_data;
        logic [3:0]  e_cc;
        logic        e_skip;
        int          c;
        n  = ins[18:16];
        rd = ins[15:14];
        a  = m_r[k][ins[13:12]];
        b  = ins[9] ? ins[7:0] : m_r[k][ins[11:10]];
        f  = alu(n, a, b);
        if (ins[8] && m_cc[k][2]) begin
            e_data = '0;
            e_cc   = m_cc[k];
            e_skip = 1'b1;
        end else begin
            e_data   = f[7:0];
            e_cc     = f[11:8];
            e_skip   = 1'b0;
            m_r[k][rd] = f[7:0];
            m_cc[k]    = f[11:8];
        end

        @(negedge clk);
        iv[k]    = 1'b1;
        ins_w[k] = ins;
        c = 0;
        while (!rdy[k] && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("accept_ready", 32'(rdy[k]), 1);
        @(posedge clk);
        #1 iv[k] = 1'b0;

        // c counts edges after the accept edge until res_valid is seen.
        c = 0;
        while (c < 20) begin
            @(posedge clk);
            #1 c++;
            if (rv[k]) break;
            check("busy_ready", 32'(rdy[k]), 0);
        end
        check("latency", c, lat_of(k) + 1);
        check("alu_a", 32'(ao[k]), 32'(a));
        check("alu_b", 32'(bo[k]), 32'(b));
        check("alu_n", 32'(no[k]), 32'(n));
        check("res_data", 32'(rd_o[k]), 32'(e_data));
        check("res_cc", 32'(rc_o[k]), 32'(e_cc));
        check("res_rd", 32'(rrd_o[k]), 32'(rd));
        check("res_skip", 32'(rs_o[k]), 32'(e_skip));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            iv[k]    = 1'b1;
            ins_w[k] = 19'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rv[k]), 1);
            check("hold_ready", 32'(rdy[k]), 0);
            check("hold_data", 32'(rd_o[k]), 32'(e_data));
            check("hold_cc", 32'(rc_o[k]), 32'(e_cc));
            check("hold_a", 32'(ao[k]), 32'(a));
        end

        @(negedge clk);
        rr[k] = 1'b1;
        @(posedge clk);
        #1;
        rr[k] = 1'b0;
        check("retire_valid", 32'(rv[k]), 0);
        check("retire_ready", 32'(rdy[k]), 1);
        check("retire_a", 32'(ao[k]), 32'(a));
        iv[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            iv[k]    = 1'b0;
            rr[k]    = 1'b0;
            ins_w[k] = '0;
            model_reset(k);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_zero(k);
            check("rst_ready", 32'(rdy[k]), 0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rel_ready", 32'(rdy[k]), 1);
            check_zero(k);
        end

        do_instr(0, mk(0, 1, 0, 0, 1, 0, 8'h05), 0);
        do_instr(0, mk(1, 2, 1, 1, 0, 0, 0), 0);
        do_instr(0, mk(0, 3, 1, 0, 1, 1, 8'h10), 10);
        do_instr(0, mk(0, 0, 3, 0, 1, 0, 0), 0);
        for (int i = 0; i < 60; i++) begin
            do_instr(0, 19'($urandom), int'($urandom_range(0, 2)));
        end

        do_instr(1, mk(0, 1, 0, 0, 1, 0, 8'h33), 0);
        do_instr(1, mk(1, 2, 1, 0, 1, 0, 8'h40), 1);

        @(negedge clk);
        iv[1]    = 1'b1;
        ins_w[1] = mk(0, 3, 1, 0, 1, 0, 8'h01);
        @(posedge clk);
        #1 iv[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check_zero(1);
        check("mid_rst_ready", 32'(rdy[1]), 0);
        model_reset(1);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_valid", 32'(rv[1]), 0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", 32'(rdy[1]), 1);
        check_zero(1);
        do_instr(1, mk(3, 0, 1, 3, 0, 0, 0), 0);
        for (int i = 0; i < 12; i++) begin
            do_instr(1, 19'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
